// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one pipelined FP less-than comparator between NREQ
// requesters; a tag pipeline steers each result back to its issuer.
module cmp_arbiter #(
  parameter int WIDTH   = 18,
  parameter int NREQ    = 4,
  parameter int CMP_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*(WIDTH+1)-1:0] req_a,
  input  logic [NREQ*(WIDTH+1)-1:0] req_b,
  output logic [WIDTH:0]            cmp_a,
  output logic [WIDTH:0]            cmp_b,
  input  logic                      cmp_less,
  output logic [NREQ-1:0]           rsp_valid,
  output logic                      rsp_less,
  input  logic                      hold,
  output logic                      busy
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0][WIDTH:0]  w_a, w_b;
  logic [IDW-1:0]            r_ptr, w_gnt, w_ptr_nxt;
  logic                      w_any, w_xfer;
  logic [CMP_LAT:0]          r_vld_pipe;
  logic [CMP_LAT:0][IDW-1:0] r_id_pipe;

  assign w_a = req_a;
  assign w_b = req_b;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s -= NREQ;
    return IDW'(s);
  endfunction

  // First valid requester scanning cyclically upward from the pointer.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[rr_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = rr_idx(r_ptr, k);
      end
    end
  end

  assign req_ready = (rst && !hold && w_any) ? (NREQ'(1) << w_gnt) : '0;
  assign w_xfer    = |req_ready;
  assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_nxt;
      cmp_a <= w_a[w_gnt];
      cmp_b <= w_b[w_gnt];
    end
  end

  // Stage k lines up with the comparator's k-th internal stage; the last
  // stage is valid in the same cycle as the matching cmp_less.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[CMP_LAT-1:0], w_xfer};
      r_id_pipe  <= {r_id_pipe[CMP_LAT-1:0], w_gnt};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_less  <= 1'b0;
    end else if (r_vld_pipe[CMP_LAT]) begin
      rsp_valid <= NREQ'(1) << r_id_pipe[CMP_LAT];
      rsp_less  <= cmp_less;
    end else begin
      rsp_valid <= '0;
      rsp_less  <= 1'b0;
    end
  end

  assign busy = (|r_vld_pipe) | (|rsp_valid);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: a cycle-level reference model (round-robin pointer,
// queue of due responses) plus directed vectors with literal expectations.
module tb_cmp_arbiter;
  localparam int W    = 18;
  localparam int N    = 4;
  localparam int LAT  = 3;
  localparam int TOT  = LAT + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][W:0]  ta, tb;
  logic [W:0]         cmp_a, cmp_b;
  logic               cmp_less;
  logic [N-1:0]       rsp_valid;
  logic               rsp_less;
  logic               hold;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cmp_arbiter #(.WIDTH(W), .NREQ(N), .CMP_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(ta), .req_b(tb), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less),
    .rsp_valid(rsp_valid), .rsp_less(rsp_less), .hold(hold), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Signed ordering key for zero / normal numbers.
  function automatic int fp_key(input logic [W:0] v);
    if (v[W:W-1] == 2'b00) return 0;
    return v[W-2] ? -(int'(v[W-3:0]) + 1) : int'(v[W-3:0]) + 1;
  endfunction

  function automatic bit fp_less(input logic [W:0] a, input logic [W:0] b);
    return fp_key(a) < fp_key(b);
  endfunction

  // External comparator: result of operands seen in cycle c appears in c+LAT.
  logic [LAT-1:0] cl_sh = '0;
  always @(posedge clk) cl_sh <= {cl_sh[LAT-2:0], fp_less(cmp_a, cmp_b)};
  assign cmp_less = cl_sh[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model, compared every cycle at the falling edge.
  typedef struct {int due; int id; bit less;} exp_t;
  exp_t m_q[$];
  int   m_ptr = 0;
  logic [W:0] m_a = '0, m_b = '0;

  initial forever begin
    int g;
    logic [N-1:0] e_rv;
    bit e_rl, e_busy;
    @(negedge clk);
    if (!rst) begin
      chk("m_rst_ready", req_ready, 0);
      chk("m_rst_rsp_valid", rsp_valid, 0);
      chk("m_rst_rsp_less", rsp_less, 0);
      chk("m_rst_busy", busy, 0);
      chk("m_rst_cmp_a", cmp_a, 0);
      chk("m_rst_cmp_b", cmp_b, 0);
      m_ptr = 0; m_q.delete(); m_a = '0; m_b = '0;
    end else begin
      g = -1;
      if (!hold)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      chk("m_ready", req_ready, (g >= 0) ? (32'd1 << g) : 0);
      chk("m_cmp_a", cmp_a, m_a);
      chk("m_cmp_b", cmp_b, m_b);
      e_rv = '0; e_rl = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        e_rv = N'(1) << m_q[0].id;
        e_rl = m_q[0].less;
        void'(m_q.pop_front());
      end
      chk("m_rsp_valid", rsp_valid, e_rv);
      chk("m_rsp_less", rsp_less, e_rl);
      e_busy = (e_rv != 0) || (m_q.size() > 0 && m_q[0].due - (TOT - 1) <= cyc);
      chk("m_busy", busy, e_busy);
      if (g >= 0) begin
        m_q.push_back('{due: cyc + TOT, id: g, less: fp_less(ta[g], tb[g])});
        m_a = ta[g]; m_b = tb[g];
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  localparam logic [W:0] ONE = 19'h27800, TWO = 19'h28000, MONE = 19'h37800;

  initial begin
    rst = 1'b0; hold = 1'b0; req_valid = '0; ta = '0; tb = '0;
    #2;
    req_valid = 4'b1111;
    #1;
    chk("reset_ready_forced", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmp_a", cmp_a, 0);
    req_valid = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single request from requester 2: 1.0 < 2.0.
    req_valid = 4'b0100; ta[2] = ONE; tb[2] = TWO;
    #1 chk("single_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    #1 chk("single_busy_t1", busy, 1);
    for (int k = 2; k <= TOT; k++) begin
      step(); #1;
      chk("single_busy", busy, 1);
      if (k < TOT) chk("single_no_early_rsp", rsp_valid, 0);
    end
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_less", rsp_less, 1);
    step(); #1;
    chk("single_busy_off", busy, 0);
    chk("single_rsp_off", rsp_valid, 0);

    // Equal, greater and negative operands (ptr is 3 here).
    req_valid = 4'b0001; ta[0] = ONE; tb[0] = ONE;
    #1 chk("eq_ready", req_ready, 4'b0001);
    step(); req_valid = 4'b0010; ta[1] = TWO; tb[1] = ONE;
    #1 chk("gt_ready", req_ready, 4'b0010);
    step(); req_valid = 4'b0100; ta[2] = MONE; tb[2] = ONE;
    #1 chk("neg_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    step(); step(); #1;
    chk("eq_rsp_valid", rsp_valid, 4'b0001);
    chk("eq_rsp_less", rsp_less, 0);
    step(); #1;
    chk("gt_rsp_valid", rsp_valid, 4'b0010);
    chk("gt_rsp_less", rsp_less, 0);
    step(); #1;
    chk("neg_rsp_valid", rsp_valid, 4'b0100);
    chk("neg_rsp_less", rsp_less, 1);
    repeat (3) step();

    // Re-enter reset to get ptr=0, then full contention.
    rst = 1'b0;
    #1 chk("rst2_busy", busy, 0);
    step(); step(); rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      ta[i] = 19'h27800 + 19'(i * 19'h800);
      tb[i] = 19'h28000 - 19'(i * 19'h400);
    end
    for (int k = 0; k < 13; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) chk("rr_grant", req_ready, 32'd1 << (k % N));
      if (k >= TOT) chk("rr_rsp_order", rsp_valid, 32'd1 << ((k - TOT) % N));
      step();
    end
    #1 chk("rr_drained", busy, 0);

    // Pointer wrap: get ptr to 3, then requesters 1 and 3.
    req_valid = 4'b0100;
    #1 chk("wrap_setup", req_ready, 4'b0100);
    step(); req_valid = 4'b1010;
    #1 chk("wrap_first_3", req_ready, 4'b1000);
    step(); req_valid = 4'b0010;
    #1 chk("wrap_then_1", req_ready, 4'b0010);
    step(); req_valid = 4'b1110;
    #1 chk("wrap_ptr_is_2", req_ready, 4'b0100);
    step(); req_valid = '0;
    repeat (6) step();

    // Hold and drain with three comparisons in flight (ptr is 3).
    req_valid = 4'b0001; step();
    req_valid = 4'b0010; step();
    req_valid = 4'b0100; step();
    hold = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("hold_no_grant", req_ready, 0);
      if (k == 2) chk("hold_rsp0", rsp_valid, 4'b0001);
      if (k == 3) chk("hold_rsp1", rsp_valid, 4'b0010);
      if (k == 4) begin
        chk("hold_rsp2", rsp_valid, 4'b0100);
        chk("hold_busy_last", busy, 1);
      end
      if (k == 5) chk("hold_busy_off", busy, 0);
      step();
    end
    hold = 1'b0;
    #1 chk("hold_release_grant", req_ready, 4'b1000);
    step(); req_valid = '0;
    repeat (6) step();

    // Reset with four comparisons in flight.
    req_valid = 4'b1111;
    repeat (4) step();
    req_valid = '0; rst = 1'b0;
    #1 chk("midrst_rsp0", rsp_valid, 0);
    step(); #1 chk("midrst_rsp1", rsp_valid, 0);
    step(); rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1 chk("midrst_no_rsp", rsp_valid, 0);
      step();
    end
    req_valid = 4'b0010; ta[1] = ONE; tb[1] = TWO;
    #1 chk("post_rst_ready", req_ready, 4'b0010);
    step(); req_valid = '0;
    for (int k = 1; k <= TOT; k++) begin
      if (k == TOT - 1) chk("post_rst_not_early", rsp_valid, 0);
      if (k < TOT) step();
    end
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 4'b0010);
    chk("post_rst_rsp_less", rsp_less, 1);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares one pipelined floating-point less-than comparator (FPSub_11_5-based, 19-bit operands) between NREQ requesters in the Ray_AABB_11_5 slab-test datapath. Arbitration is round-robin. The block tags each issued comparison so that its result returns to the requester that issued it. It also provides a hold/drain control so the comparator can be quiesced before reconfiguration.

## Interface
- WIDTH, 18: operand MSB index; operands are [WIDTH:0] (19 bits: exn[18:17], sign[16], exp[15:11], frac[10:0]).
- NREQ, 4: number of requesters (2..8).
- CMP_LAT, 3: cycles from cmp_a/cmp_b presented at the comparator to the matching cmp_less value; includes the comparator's output register.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, **active-low**.
- req_valid  in  NREQ  per-requester request strobe.
- req_ready  out  NREQ  per-requester grant; a transfer happens when req_valid[i] & req_ready[i].
- req_a  in  NREQ*(WIDTH+1)  operand A, requester i at slice [i*(WIDTH+1) +: WIDTH+1].
- req_b  in  NREQ*(WIDTH+1)  operand B, same packing.
- cmp_a  out  WIDTH+1  registered operand A to the comparator.
- cmp_b  out  WIDTH+1  registered operand B to the comparator.
- cmp_less  in  1  comparator result (1 = A < B).
- rsp_valid  out  NREQ  one-hot result strobe, registered.
- rsp_less  out  1  result bit, meaningful only while rsp_valid != 0.
- hold  in  1  when 1, no new grants are issued.
- busy  out  1  1 while any comparison is in flight.

## Operation
- **Arbitration (combinational):**
  - req_ready is one-hot or zero.
  - When hold=0 and any req_valid is set, the winner g is the first set bit scanning cyclically from ptr upward.
  - req_ready[g]=1 regardless of other requesters.
  - When hold=1, req_ready=0.
- **Pointer:**
  - On a transfer, ptr <= (g+1) mod NREQ.
  - With no transfer, ptr is unchanged.
  - Reset value is 0.
- **Issue:**
  - On a transfer, cmp_a/cmp_b <= the slices of requester g.
  - Without a transfer, cmp_a/cmp_b hold their last value; the comparator output for that slot is ignored.
- **Tag pipeline:** CMP_LAT+1 stages of {valid, id[clog2(NREQ)-1:0]}.
  - Stage 0 loads {transfer, g} each cycle.
  - Every stage advances every cycle. There is no stall: responses have no backpressure and requesters must always accept them.
- **Response:**
  - When the last tag stage is valid: rsp_valid <= one-hot(id) and rsp_less <= cmp_less.
  - Otherwise: rsp_valid <= 0 and rsp_less <= 0.
- **busy** = OR of all tag-stage valid bits and rsp_valid != 0 (combinational).
- **Throughput:** one comparison per cycle total. Results return in issue order.
- **Fairness:** with all NREQ requesting continuously, each requester is granted exactly once every NREQ cycles.
- **Reset (rst=0, asynchronous):**
  - ptr=0; all tags invalid; cmp_a=cmp_b=0; rsp_valid=0; rsp_less=0.
  - busy=0; req_ready follows the combinational rule, forced to 0 while rst=0.
- **Reset mid-operation:** in-flight comparisons are discarded and produce no response. After release, the stale cmp_less values are ignored because their tags are invalid.

## Timing
- Handshake in cycle t → cmp_a/cmp_b valid in cycle t+1 → cmp_less valid in cycle t+1+CMP_LAT → rsp_valid high in cycle t+2+CMP_LAT.
- Total latency is CMP_LAT+2 cycles (5 with defaults). rsp_valid is a one-cycle pulse per request.
- **hold timing:** hold asserted in cycle t blocks grants in cycle t. busy falls at the end of the cycle carrying the last response; from that point the comparator may be reconfigured.
- **Simultaneous events:**
  - A requester deasserting req_valid in a cycle where it is not ready loses nothing.
  - The arbiter's own response and a new grant to the same requester may coincide.

## Test plan
- **Single request:**
  - Stimulus: requester 2 sends A=0x27800 (1.0), B=0x28000 (2.0) at cycle 10.
  - Required: req_ready[2]=1 at cycle 10; rsp_valid=4'b0100 and rsp_less=1 at cycle 15; busy high from cycle 11 through 15.
- **Equal and greater operands:**
  - A=B=0x27800 → rsp_less=0.
  - A=0x28000, B=0x27800 → rsp_less=0.
- **Contention:**
  - Stimulus: all 4 requesters hold valid from cycle 0 with ptr=0.
  - Required: grants 0,1,2,3,0,… on consecutive cycles; responses arrive in the same order starting at cycle 5, one per cycle.
- **Pointer wrap:**
  - Stimulus: ptr=3; requesters 1 and 3 are valid.
  - Required: 3 is granted, then 1 next cycle; ptr ends at 2.
- **Hold and drain:**
  - Stimulus: 3 requests are in flight; hold rises at cycle 20.
  - Required: req_ready=0 from cycle 20; all 3 responses still delivered; busy=0 after the last one; no grants until hold falls.
- **Reset mid-flight:**
  - Stimulus: rst pulsed low for 2 cycles with 4 comparisons in flight.
  - Required: rsp_valid stays 0 for all of them; all outputs are 0 during reset; a new request after release returns after exactly 5 cycles.
